// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared FSM type and index-width helper for rom_port_arbiter.
//   No ports; imported by rr_picker and rom_port_arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} rom_arb_state_t;

    // Width of an index into n items; never zero so single-bit vectors stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector.
//   req     - request vector, one bit per requester
//   rr_ptr  - index with highest priority this round
//   grant   - first requesting index at or after rr_ptr (wrapping)
//   any_req - at least one request present
module rr_picker
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int IDX_WIDTH = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [IDX_WIDTH-1:0] grant,
    output logic                 any_req
);

    logic [IDX_WIDTH-1:0] idx;

    // Scan from the farthest offset down so the nearest requester overwrites last and wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
            if (req[idx]) grant = idx;
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one boot ROM port between NUM_REQ requesters, round-robin,
// one outstanding transaction, single-cycle ROM request pulse and a per-access timeout.
//   clk, rst_n     - clock, asynchronous active-low reset
//   req_valid      - per-port level request, held until that port's resp_valid
//   req_addr       - per-port address, packed NUM_REQ x ADDR_WIDTH
//   resp_valid     - one-hot, one-cycle response pulse to the granted port
//   resp_rdata     - response data, valid with resp_valid (0 on timeout)
//   resp_error     - response error, valid with resp_valid (1 on timeout)
//   rom_request    - one-cycle request pulse to the ROM
//   rom_addr       - ROM address, valid while rom_request
//   rom_read_data  - ROM data, valid with rom_ready
//   rom_ready      - ROM completion strobe (ignored outside WAIT)
//   rom_error      - ROM error, valid with rom_ready
module rom_port_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_rdata,
    output logic                          resp_error,
    output logic                          rom_request,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_read_data,
    input  logic                          rom_ready,
    input  logic                          rom_error
);

    localparam int IDX_WIDTH   = idx_width(NUM_REQ);
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES);

    rom_arb_state_t         state, state_next;
    logic [IDX_WIDTH-1:0]   rr_ptr, grant, pick;
    logic [TIMER_WIDTH-1:0] timer;
    logic                   any_req, take, expired, finish;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH)) u_picker (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .grant   (pick),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (rom_ready || expired) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rom_ready is checked first in finish's data path, so it wins over a same-cycle expiry.
    always_comb begin
        expired = timer == TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
        take    = state == IDLE && any_req;
        finish  = state == WAIT && (rom_ready || expired);
    end

    // rom_request is set on the IDLE->ISSUE edge so it is high exactly during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            grant       <= '0;
            timer       <= '0;
            rom_request <= 1'b0;
            rom_addr    <= '0;
            resp_valid  <= '0;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
        end else begin
            rom_request <= take;
            resp_valid  <= '0;
            timer       <= (state == WAIT) ? timer + 1'b1 : '0;
            if (take) begin
                grant    <= pick;
                rom_addr <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
            end
            if (finish) begin
                resp_valid <= NUM_REQ'(1) << grant;
                resp_rdata <= rom_ready ? rom_read_data : '0;
                resp_error <= rom_ready ? rom_error : 1'b1;
                rr_ptr     <= (grant == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed and randomized self-checking bench for rom_port_arbiter.
module tb_rom_port_arbiter;

    localparam int T = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   req_valid = '0;
    logic [127:0] req_addr = '0;
    logic [1:0]   resp_valid;
    logic [63:0]  resp_rdata;
    logic         resp_error;
    logic         rom_request;
    logic [63:0]  rom_addr;
    logic [63:0]  rom_read_data = '0;
    logic         rom_ready = 1'b0;
    logic         rom_error = 1'b0;
    logic         stray = 1'b0;
    int           checks = 0;
    int           failures = 0;

    rom_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(64), .DATA_WIDTH(64), .TIMEOUT_CYCLES(T)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_error    (resp_error),
        .rom_request   (rom_request),
        .rom_addr      (rom_addr),
        .rom_read_data (rom_read_data),
        .rom_ready     (rom_ready),
        .rom_error     (rom_error)
    );

    always #5 clk = ~clk;

    // ROM behaviour is a pure function of the address: latency (0 = never answers), data, error.
    function automatic int rom_lat(input logic [63:0] a);
        if (a[21:20] == 2'b11) return T;
        if (a[19:16] == 4'hF) return 0;
        if (a[19:16] == 4'h0) return 2;
        return int'(a[19:16]);
    endfunction

    function automatic logic [63:0] rom_data(input logic [63:0] a);
        return a ^ 64'h0000_0000_0002_8583;
    endfunction

    function automatic logic rom_err(input logic [63:0] a);
        return a[13];
    endfunction

    int          rom_cnt = 0;
    logic [63:0] rom_cur = '0;

    always @(negedge clk or negedge rst_n) begin
        rom_ready = 1'b0;
        rom_error = 1'b0;
        if (!rst_n) rom_cnt = 0;
        else begin
            if (rom_cnt > 0) begin
                rom_cnt--;
                if (rom_cnt == 0) begin
                    rom_ready = 1'b1;
                    rom_read_data = rom_data(rom_cur);
                    rom_error = rom_err(rom_cur);
                end
            end
            if (stray) begin
                rom_ready = 1'b1;
                rom_read_data = 64'hBAD0_BAD0;
                rom_error = 1'b1;
            end
            if (rom_request) begin
                rom_cur = rom_addr;
                rom_cnt = rom_lat(rom_addr);
            end
        end
    end

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        req_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one request from the current negedge and records what the DUT did, cycle-numbered from 1.
    task automatic observe_txn(input logic p, input logic [63:0] a, output int rq_cyc, output int rq_cnt,
                               output logic [63:0] rq_addr, output int rs_cyc, output logic [1:0] rs_vec,
                               output logic [63:0] rs_data, output logic rs_err);
        rq_cyc = -1; rq_cnt = 0; rq_addr = '0; rs_cyc = -1; rs_vec = '0; rs_data = '0; rs_err = 1'b0;
        req_addr[p*64 +: 64] = a;
        req_valid[p] = 1'b1;
        for (int k = 1; k <= 40 && (rs_cyc < 0 || k <= rs_cyc + 3); k++) begin
            @(negedge clk);
            if (rom_request) begin
                rq_cnt++;
                if (rq_cyc < 0) begin rq_cyc = k; rq_addr = rom_addr; end
            end
            if (resp_valid != 2'b00) begin
                if (rs_cyc < 0) begin rs_cyc = k; rs_vec = resp_valid; rs_data = resp_rdata; rs_err = resp_error; end
                req_valid[p] = 1'b0;
            end
        end
        req_valid[p] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (resp_valid !== 2'b00) begin failures++; $display("FAIL reset_resp_valid got=%b exp=00", resp_valid); end
        checks++; if (resp_rdata !== 64'h0) begin failures++; $display("FAIL reset_resp_rdata got=%h exp=0", resp_rdata); end
        checks++; if (resp_error !== 1'b0) begin failures++; $display("FAIL reset_resp_error got=%b exp=0", resp_error); end
        checks++; if (rom_request !== 1'b0) begin failures++; $display("FAIL reset_rom_request got=%b exp=0", rom_request); end
        checks++; if (rom_addr !== 64'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int rq_cyc, rq_cnt, rs_cyc;
        logic [63:0] rq_addr, rs_data;
        logic [1:0] rs_vec;
        logic rs_err;
        reset_dut();
        observe_txn(1'b0, 64'h10, rq_cyc, rq_cnt, rq_addr, rs_cyc, rs_vec, rs_data, rs_err);
        checks++; if (rq_cyc !== 1) begin failures++; $display("FAIL single_req_cycle got=%0d exp=1", rq_cyc); end
        checks++; if (rq_cnt !== 1) begin failures++; $display("FAIL single_req_pulses got=%0d exp=1", rq_cnt); end
        checks++; if (rq_addr !== 64'h10) begin failures++; $display("FAIL single_rom_addr got=%h exp=10", rq_addr); end
        checks++; if (rs_cyc !== 4) begin failures++; $display("FAIL single_resp_cycle got=%0d exp=4", rs_cyc); end
        checks++; if (rs_vec !== 2'b01) begin failures++; $display("FAIL single_resp_vec got=%b exp=01", rs_vec); end
        checks++; if (rs_data !== 64'h0000_0000_0002_8593) begin failures++; $display("FAIL single_rdata got=%h exp=28593", rs_data); end
        checks++; if (rs_err !== 1'b0) begin failures++; $display("FAIL single_error got=%b exp=0", rs_err); end
    endtask

    task automatic test_contention();
        int order[$];
        reset_dut();
        req_addr = {64'h200, 64'h100};
        req_valid = 2'b11;
        for (int k = 0; k < 100 && order.size() < 4; k++) begin
            @(negedge clk);
            if (resp_valid == 2'b01) order.push_back(0);
            else if (resp_valid == 2'b10) order.push_back(1);
            else if (resp_valid != 2'b00) order.push_back(9);
        end
        req_valid = '0;
        checks++; if (order.size() != 4) begin failures++; $display("FAIL contention_count got=%0d exp=4", order.size()); end
        for (int i = 0; i < order.size(); i++) begin
            checks++; if (order[i] !== i % 2) begin failures++; $display("FAIL contention_grant%0d got=%0d exp=%0d", i, order[i], i % 2); end
        end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        int resps = 0;
        int wide = 0;
        logic prev = 1'b0;
        reset_dut();
        req_addr[127:64] = 64'h300;
        req_valid = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rom_request) begin pulses.push_back(k); if (prev) wide++; end
            prev = rom_request;
            if (resp_valid[1]) begin resps++; if (resps == 3) req_valid = '0; end
        end
        checks++; if (pulses.size() != 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", pulses.size()); end
        checks++; if (wide != 0) begin failures++; $display("FAIL b2b_wide_pulse got=%0d exp=0", wide); end
        checks++; if (resps != 3) begin failures++; $display("FAIL b2b_responses got=%0d exp=3", resps); end
        if (pulses.size() > 0) begin
            checks++; if (pulses[0] != 1) begin failures++; $display("FAIL b2b_first got=%0d exp=1", pulses[0]); end
        end
        for (int i = 1; i < pulses.size(); i++) begin
            checks++; if (pulses[i] - pulses[i-1] != 4) begin failures++; $display("FAIL b2b_spacing%0d got=%0d exp=4", i, pulses[i] - pulses[i-1]); end
        end
    endtask

    task automatic test_slave_error();
        int rq_cyc, rq_cnt, rs_cyc;
        logic [63:0] rq_addr, rs_data;
        logic [1:0] rs_vec;
        logic rs_err;
        reset_dut();
        observe_txn(1'b0, 64'h2000, rq_cyc, rq_cnt, rq_addr, rs_cyc, rs_vec, rs_data, rs_err);
        checks++; if (rs_cyc !== 4) begin failures++; $display("FAIL slverr_resp_cycle got=%0d exp=4", rs_cyc); end
        checks++; if (rs_vec !== 2'b01) begin failures++; $display("FAIL slverr_resp_vec got=%b exp=01", rs_vec); end
        checks++; if (rs_err !== 1'b1) begin failures++; $display("FAIL slverr_error got=%b exp=1", rs_err); end
        checks++; if (rs_data !== 64'h2A583) begin failures++; $display("FAIL slverr_rdata got=%h exp=2a583", rs_data); end
    endtask

    task automatic test_timeout();
        int rq_cyc, rq_cnt, rs_cyc;
        int bad = 0;
        logic [63:0] rq_addr, rs_data;
        logic [1:0] rs_vec;
        logic rs_err;
        reset_dut();
        observe_txn(1'b1, 64'hF0000, rq_cyc, rq_cnt, rq_addr, rs_cyc, rs_vec, rs_data, rs_err);
        checks++; if (rq_cyc !== 1 || rq_cnt !== 1) begin failures++; $display("FAIL timeout_req got=%0d/%0d exp=1/1", rq_cyc, rq_cnt); end
        checks++; if (rs_cyc !== T + 2) begin failures++; $display("FAIL timeout_resp_cycle got=%0d exp=%0d", rs_cyc, T + 2); end
        checks++; if (rs_vec !== 2'b10) begin failures++; $display("FAIL timeout_resp_vec got=%b exp=10", rs_vec); end
        checks++; if (rs_err !== 1'b1) begin failures++; $display("FAIL timeout_error got=%b exp=1", rs_err); end
        checks++; if (rs_data !== 64'h0) begin failures++; $display("FAIL timeout_rdata got=%h exp=0", rs_data); end
        @(posedge clk);
        stray = 1'b1;
        @(posedge clk);
        stray = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (resp_valid != 2'b00 || rom_request) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stray_ready_activity got=%0d exp=0", bad); end
    endtask

    task automatic test_reset_mid_wait();
        int rq_cyc, rq_cnt, rs_cyc;
        int bad = 0;
        logic [63:0] rq_addr, rs_data;
        logic [1:0] rs_vec;
        logic rs_err;
        reset_dut();
        req_addr[63:0] = 64'h50000;
        req_valid = 2'b01;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        checks++; if (rom_addr !== 64'h0) begin failures++; $display("FAIL midrst_rom_addr got=%h exp=0", rom_addr); end
        checks++; if (resp_valid !== 2'b00 || rom_request !== 1'b0) begin failures++; $display("FAIL midrst_strobes got=%b/%b exp=00/0", resp_valid, rom_request); end
        checks++; if (resp_rdata !== 64'h0 || resp_error !== 1'b0) begin failures++; $display("FAIL midrst_resp got=%h/%b exp=0/0", resp_rdata, resp_error); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid != 2'b00 || rom_request) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL midrst_late_activity got=%0d exp=0", bad); end
        observe_txn(1'b1, 64'h10, rq_cyc, rq_cnt, rq_addr, rs_cyc, rs_vec, rs_data, rs_err);
        checks++; if (rs_cyc !== 4 || rs_vec !== 2'b10) begin failures++; $display("FAIL midrst_fresh_resp got=%0d/%b exp=4/10", rs_cyc, rs_vec); end
        checks++; if (rs_data !== 64'h28593 || rs_err !== 1'b0) begin failures++; $display("FAIL midrst_fresh_data got=%h/%b exp=28593/0", rs_data, rs_err); end
    endtask

    // Transaction-level model: a free arbiter issues one cycle after it sees any request, picks by
    // round-robin pointer, and answers L+1 cycles after issue (or T+1 when the ROM never answers).
    task automatic test_random();
        int exp_resp = -1;
        int lat;
        logic ptr = 1'b0;
        logic gp = 1'b0;
        logic busy = 1'b0;
        logic exp_rr, exp_err;
        logic [1:0] rq, exp_vec;
        logic [63:0] a, exp_data = '0;
        exp_err = 1'b0;
        reset_dut();
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            rq = req_valid;
            exp_rr = !busy && rq != 2'b00;
            exp_vec = (n == exp_resp) ? (gp ? 2'b10 : 2'b01) : 2'b00;
            checks++; if (resp_valid !== exp_vec) begin failures++; $display("FAIL rand_resp_valid cycle=%0d got=%b exp=%b", n, resp_valid, exp_vec); end
            if (n == exp_resp) begin
                checks++; if (resp_rdata !== exp_data || resp_error !== exp_err) begin failures++; $display("FAIL rand_resp_data cycle=%0d got=%h/%b exp=%h/%b", n, resp_rdata, resp_error, exp_data, exp_err); end
                ptr = ~gp;
                busy = 1'b0;
                req_valid[gp] = 1'b0;
            end
            checks++; if (rom_request !== exp_rr) begin failures++; $display("FAIL rand_rom_request cycle=%0d got=%b exp=%b", n, rom_request, exp_rr); end
            if (exp_rr) begin
                gp = rq[ptr] ? ptr : ~ptr;
                a = req_addr[gp*64 +: 64];
                checks++; if (rom_addr !== a) begin failures++; $display("FAIL rand_rom_addr cycle=%0d got=%h exp=%h", n, rom_addr, a); end
                lat = rom_lat(a);
                busy = 1'b1;
                exp_resp = n + ((lat > 0) ? lat : T) + 1;
                exp_data = (lat > 0) ? rom_data(a) : 64'h0;
                exp_err = (lat > 0) ? rom_err(a) : 1'b1;
            end
            if (!req_valid[0] && $urandom_range(3) == 0) begin req_addr[63:0] = {$urandom, $urandom}; req_valid[0] = 1'b1; end
            if (!req_valid[1] && $urandom_range(3) == 0) begin req_addr[127:64] = {$urandom, $urandom}; req_valid[1] = 1'b1; end
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_slave_error();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
